// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: ALU and branch opcodes, the internal
// request bundle, and scheduler limits.
package alu_sched_pkg;

   localparam int MAX_ALU_REQ = 8;
   localparam int XLEN        = 32;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
   } branch_op_e;

   typedef struct packed {
      logic [XLEN-1:0] src_a;
      logic [XLEN-1:0] src_b;
      alu_op_e         alu_control;
      logic            is_branch;
      branch_op_e      branch_op;
   } alu_req_t;

endpackage

// File: rtl/alu_sched_if.sv
// Request and response channels of the ALU scheduler; master is the
// requester/consumer side, slave is the scheduler.
interface alu_sched_if #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 2
);
   import alu_sched_pkg::*;

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_src_a;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_src_b;
   alu_op_e [NUM_REQ-1:0]         req_alu_control;
   logic [NUM_REQ-1:0]            req_is_branch;
   branch_op_e [NUM_REQ-1:0]      req_branch_op;

   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [ID_W-1:0]               rsp_id;
   logic [WIDTH-1:0]              rsp_result;
   logic                          rsp_branch_true;
   logic                          busy;

   modport master (
      output req_valid, req_src_a, req_src_b, req_alu_control, req_is_branch,
             req_branch_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_branch_true, busy
   );

   modport slave (
      input  req_valid, req_src_a, req_src_b, req_alu_control, req_is_branch,
             req_branch_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_branch_true, busy
   );

endinterface

// File: rtl/alu_sched_alu.sv
// Integer ALU with a side branch-compare output; branch_true is only ever
// set for branch requests.
module alu
   import alu_sched_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  alu_op_e          alu_control,
   input  logic             is_branch,
   input  branch_op_e       branch_op,
   output logic [WIDTH-1:0] alu_result,
   output logic             alu_branch_true
);
   localparam int SH_W = $clog2(WIDTH);

   logic [SH_W-1:0] shamt;
   logic            lt_s, lt_u, eq;
   logic            cond;

   assign shamt = src_b[SH_W-1:0];
   assign lt_s  = $signed(src_a) < $signed(src_b);
   assign lt_u  = src_a < src_b;
   assign eq    = src_a == src_b;

   always_comb begin
      alu_result = '0;
      case (alu_control)
         ALU_ADD:  alu_result = src_a + src_b;
         ALU_SUB:  alu_result = src_a - src_b;
         ALU_AND:  alu_result = src_a & src_b;
         ALU_OR:   alu_result = src_a | src_b;
         ALU_XOR:  alu_result = src_a ^ src_b;
         ALU_SLL:  alu_result = src_a << shamt;
         ALU_SRL:  alu_result = src_a >> shamt;
         ALU_SRA:  alu_result = WIDTH'($signed(src_a) >>> shamt);
         ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, lt_s};
         ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, lt_u};
         default:  alu_result = '0;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      case (branch_op)
         BR_EQ:   cond = eq;
         BR_NE:   cond = !eq;
         BR_LT:   cond = lt_s;
         BR_GE:   cond = !lt_s;
         BR_LTU:  cond = lt_u;
         BR_GEU:  cond = !lt_u;
         default: cond = 1'b0;
      endcase
   end

   assign alu_branch_true = is_branch && cond;

endmodule

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr
// (wrapping) wins.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 any
);
   localparam int IW = $clog2(N);

   logic [IW-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!any && req[idx]) begin
            any       = 1'b1;
            grant_idx = idx;
         end
      end
      if (any) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/alu_sched.sv
// Shares one alu between NUM_REQ requesters: round-robin grant, at most one
// op per cycle, single registered response with backpressure.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 2
) (
   input logic        clk,
   input logic        rst,
   alu_sched_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > MAX_ALU_REQ) begin : g_bad_num_req
      $error("alu_sched: NUM_REQ out of range 2..%0d", MAX_ALU_REQ);
   end
   if (WIDTH > XLEN) begin : g_bad_width
      $error("alu_sched: WIDTH exceeds %0d", XLEN);
   end

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    win_idx;
   logic [ID_W-1:0]    sel_idx;
   logic [NUM_REQ-1:0] win_oh;
   logic               win_any;
   logic               can_accept;
   logic               accept;
   alu_req_t           sel;
   logic [WIDTH-1:0]   alu_result;
   logic               alu_branch_true;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req       (bus.req_valid),
      .ptr       (rr_ptr),
      .grant     (win_oh),
      .grant_idx (win_idx),
      .any       (win_any)
   );

   // Refill the response register in the same cycle it drains.
   assign can_accept    = !bus.rsp_valid || bus.rsp_ready;
   assign accept        = win_any && can_accept;
   assign bus.req_ready = (rst || !can_accept) ? '0 : win_oh;
   assign bus.busy      = bus.rsp_valid || (|bus.req_valid);

   // Idle cycles park the ALU on rr_ptr's operands; the result is unused.
   assign sel_idx = win_any ? win_idx : rr_ptr;

   always_comb begin
      sel.src_a       = XLEN'(bus.req_src_a[sel_idx]);
      sel.src_b       = XLEN'(bus.req_src_b[sel_idx]);
      sel.alu_control = bus.req_alu_control[sel_idx];
      sel.is_branch   = bus.req_is_branch[sel_idx];
      sel.branch_op   = bus.req_branch_op[sel_idx];
   end

   alu #(.WIDTH(WIDTH)) u_alu (
      .src_a           (sel.src_a[WIDTH-1:0]),
      .src_b           (sel.src_b[WIDTH-1:0]),
      .alu_control     (sel.alu_control),
      .is_branch       (sel.is_branch),
      .branch_op       (sel.branch_op),
      .alu_result      (alu_result),
      .alu_branch_true (alu_branch_true)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rsp_valid       <= 1'b0;
         bus.rsp_id          <= '0;
         bus.rsp_result      <= '0;
         bus.rsp_branch_true <= 1'b0;
         rr_ptr              <= '0;
      end else if (accept) begin
         bus.rsp_valid       <= 1'b1;
         bus.rsp_id          <= win_idx;
         bus.rsp_result      <= alu_result;
         bus.rsp_branch_true <= alu_branch_true;
         rr_ptr              <= (win_idx == ID_W'(NUM_REQ-1)) ? '0 : ID_W'(win_idx + 1'b1);
      end else if (bus.rsp_ready) begin
         bus.rsp_valid       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: directed vectors followed by a random soak
// against an ALU reference and a round-robin grant model.
module tb_alu_sched;
   import alu_sched_pkg::*;

   localparam int W   = 32;
   localparam int N   = 4;
   localparam int IDW = $clog2(N);

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   res;
      logic           br;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_sched_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
   alu_sched #(.WIDTH(W), .NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t           sbq[$];
   int             id_log[$];
   logic [W-1:0]   exp_res [N];
   logic           exp_br  [N];
   int             waited  [N];
   int             total = 0, bad = 0;
   int             n_acc = 0, n_rsp = 0;
   logic [IDW-1:0] m_ptr;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_alu(alu_op_e op, logic [W-1:0] a, logic [W-1:0] b);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << b[4:0];
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return W'($signed(a) >>> b[4:0]);
         ALU_SLT:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         ALU_SLTU: return (a < b) ? W'(1) : W'(0);
         default:  return '0;
      endcase
   endfunction

   function automatic logic ref_br(logic isb, branch_op_e op, logic [W-1:0] a, logic [W-1:0] b);
      if (!isb) return 1'b0;
      case (op)
         BR_EQ:   return a == b;
         BR_NE:   return a != b;
         BR_LT:   return $signed(a) < $signed(b);
         BR_GE:   return $signed(a) >= $signed(b);
         BR_LTU:  return a < b;
         BR_GEU:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Monitor: models rsp_valid as "scoreboard non-empty" and the grant as a
   // round-robin search, so both req_ready and the response stream are checked.
   logic           pv_stall, pv_br;
   logic [W-1:0]   pv_res;
   logic [IDW-1:0] pv_id;
   logic [N-1:0]   pv_req;
   logic [W-1:0]   pv_a [N];

   always @(negedge clk) begin : mon
      logic         full;
      logic [N-1:0] exp_rdy;
      int           win, j;
      exp_t         e;
      if (rst) begin
         sbq.delete();
         m_ptr    = '0;
         pv_stall = 1'b0;
         pv_req   = '0;
         for (int i = 0; i < N; i++) waited[i] = 0;
      end else begin
         full = (sbq.size() != 0);
         check("rsp_valid", bus.rsp_valid, full);
         check("busy", bus.busy, full || (|bus.req_valid));
         if (pv_stall) begin
            check("stall_hold_res", bus.rsp_result, pv_res);
            check("stall_hold_id", bus.rsp_id, pv_id);
            check("stall_hold_br", bus.rsp_branch_true, pv_br);
         end
         for (int i = 0; i < N; i++) if (pv_req[i]) begin
            check("req_hold_valid", bus.req_valid[i], 1'b1);
            check("req_hold_a", bus.req_src_a[i], pv_a[i]);
         end
         if (full && bus.rsp_valid) begin
            check("rsp_id", bus.rsp_id, sbq[0].id);
            check("rsp_result", bus.rsp_result, sbq[0].res);
            check("rsp_branch_true", bus.rsp_branch_true, sbq[0].br);
            if (bus.rsp_ready) begin
               id_log.push_back(int'(bus.rsp_id));
               void'(sbq.pop_front());
               n_rsp++;
            end
         end
         win = -1;
         if (!full || bus.rsp_ready) begin
            for (int k = 0; k < N; k++) begin
               j = (int'(m_ptr) + k) % N;
               if (win < 0 && bus.req_valid[j]) win = j;
            end
         end
         exp_rdy = '0;
         if (win >= 0) exp_rdy[win] = 1'b1;
         check("req_ready", bus.req_ready, exp_rdy);
         if (win >= 0) begin
            check("fair_wait", waited[win] < N, 1'b1);
            e.id  = IDW'(win);
            e.res = exp_res[win];
            e.br  = exp_br[win];
            sbq.push_back(e);
            n_acc++;
            for (int k = 0; k < N; k++) if (k != win && bus.req_valid[k]) waited[k]++;
            waited[win] = 0;
            m_ptr = IDW'((win + 1) % N);
         end
         pv_stall = bus.rsp_valid && !bus.rsp_ready;
         pv_res   = bus.rsp_result;
         pv_id    = bus.rsp_id;
         pv_br    = bus.rsp_branch_true;
         pv_req   = bus.req_valid;
         if (win >= 0) pv_req[win] = 1'b0;
         for (int i = 0; i < N; i++) pv_a[i] = bus.req_src_a[i];
      end
   end

   task automatic raise(int i, alu_op_e op, logic [W-1:0] a, logic [W-1:0] b,
                        logic isb, branch_op_e bop, logic [W-1:0] er, logic eb);
      bus.req_src_a[i]       = a;
      bus.req_src_b[i]       = b;
      bus.req_alu_control[i] = op;
      bus.req_is_branch[i]   = isb;
      bus.req_branch_op[i]   = bop;
      exp_res[i]             = er;
      exp_br[i]              = eb;
      bus.req_valid[i]       = 1'b1;
   endtask

   task automatic wait_acc(int i);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.req_valid[i] && bus.req_ready[i]) && n < 50);
      check("accept_timeout", n < 50, 1'b1);
      @(posedge clk);
      #1;
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic idle(int c);
      repeat (c) @(posedge clk);
      #1;
   endtask

   task automatic rand_req(int i);
      alu_op_e        op;
      branch_op_e     bop;
      logic [W-1:0]   a, b;
      logic           isb;
      op  = alu_op_e'($urandom_range(9, 0));
      bop = branch_op_e'($urandom_range(5, 0));
      a   = $urandom;
      b   = ($urandom_range(3, 0) == 0) ? a : $urandom;
      isb = $urandom_range(1, 0) == 1;
      raise(i, op, a, b, isb, bop, ref_alu(op, a, b), ref_br(isb, bop, a, b));
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [N-1:0] acc;
      int           a0, r0;
      bus.req_valid       = '0;
      bus.req_src_a       = '0;
      bus.req_src_b       = '0;
      bus.req_alu_control = {N{ALU_ADD}};
      bus.req_is_branch   = '0;
      bus.req_branch_op   = {N{BR_EQ}};
      bus.rsp_ready       = 1'b1;
      rst = 1'b0;
      #1 rst = 1'b1;
      idle(2);

      // Reset state, with a request already pending: grant held off
      raise(0, ALU_ADD, 32'h0000000A, 32'h00000005, 1'b0, BR_EQ, 32'h0000000F, 1'b0);
      #1;
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_rsp_id", bus.rsp_id, '0);
      check("rst_rsp_result", bus.rsp_result, '0);
      check("rst_rsp_br", bus.rsp_branch_true, 1'b0);
      check("rst_req_ready", bus.req_ready, '0);
      idle(1);
      rst = 1'b0;

      // Single ADD
      wait_acc(0);
      check("t1_valid", bus.rsp_valid, 1'b1);
      check("t1_id", bus.rsp_id, 0);
      check("t1_result", bus.rsp_result, 32'h0000000F);
      check("t1_br", bus.rsp_branch_true, 1'b0);

      // Requester 3 alone wraps the pointer back to 0
      raise(3, ALU_OR, 32'h000000F0, 32'h0000000F, 1'b0, BR_EQ, 32'h000000FF, 1'b0);
      wait_acc(3);
      idle(2);

      // Contention: back-to-back responses id0 then id1
      id_log.delete();
      raise(0, ALU_SUB, 32'h0000000A, 32'h00000005, 1'b0, BR_EQ, 32'h00000005, 1'b0);
      raise(1, ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 1'b0, BR_EQ, 32'h00000001, 1'b0);
      fork wait_acc(0); wait_acc(1); join
      idle(2);
      check("cont_count", id_log.size(), 2);
      check("cont_first", id_log[0], 0);
      check("cont_second", id_log[1], 1);

      // Pointer now past 1: req0 beats req1 again
      id_log.delete();
      raise(1, ALU_XOR, 32'h000000F0, 32'h0000000F, 1'b0, BR_EQ, 32'h000000FF, 1'b0);
      raise(0, ALU_ADD, 32'h00000003, 32'h00000004, 1'b0, BR_EQ, 32'h00000007, 1'b0);
      fork wait_acc(0); wait_acc(1); join
      idle(2);
      check("wrap_first", id_log[0], 0);
      check("wrap_second", id_log[1], 1);

      // Branch compare
      raise(1, ALU_SUB, 32'hF0000000, 32'hF0000000, 1'b1, BR_EQ, 32'h00000000, 1'b1);
      wait_acc(1);
      check("br_id", bus.rsp_id, 1);
      check("br_true", bus.rsp_branch_true, 1'b1);
      check("br_result", bus.rsp_result, 32'h00000000);
      idle(2);

      // Backpressure, then same-edge drain and refill
      bus.rsp_ready = 1'b0;
      raise(0, ALU_SRA, 32'h80000000, 32'h00000001, 1'b0, BR_EQ, 32'hC0000000, 1'b0);
      wait_acc(0);
      raise(1, ALU_SRL, 32'h80000000, 32'h00000001, 1'b0, BR_EQ, 32'h40000000, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_hold_result", bus.rsp_result, 32'hC0000000);
         check("bp_req_ready", bus.req_ready, '0);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      wait_acc(1);
      check("bp_refill_valid", bus.rsp_valid, 1'b1);
      check("bp_refill_id", bus.rsp_id, 1);
      check("bp_refill_result", bus.rsp_result, 32'h40000000);
      idle(2);

      // Asynchronous reset while a response is stalled
      bus.rsp_ready = 1'b0;
      raise(2, ALU_ADD, 32'h00000001, 32'h00000001, 1'b0, BR_EQ, 32'h00000002, 1'b0);
      wait_acc(2);
      #1 rst = 1'b1;
      #1;
      check("arst_valid", bus.rsp_valid, 1'b0);
      check("arst_id", bus.rsp_id, '0);
      check("arst_result", bus.rsp_result, '0);
      check("arst_br", bus.rsp_branch_true, 1'b0);
      idle(1);
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      id_log.delete();
      raise(1, ALU_AND, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, BR_EQ, 32'h0F000F00, 1'b0);
      raise(0, ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 1'b1, BR_GEU, 32'h00000001, 1'b0);
      fork wait_acc(0); wait_acc(1); join
      idle(2);
      check("post_rst_first", id_log[0], 0);

      // Random soak
      a0 = n_acc;
      r0 = n_rsp;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         acc = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i] && $urandom_range(1, 0) == 1) rand_req(i);
         end
         bus.rsp_ready = $urandom_range(3, 0) != 0;
      end
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         acc = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         bus.req_valid = bus.req_valid & ~acc;
      end
      idle(3);
      check("soak_drained", sbq.size(), 0);
      check("soak_no_loss", n_acc - a0, n_rsp - r0);
      check("soak_traffic", (n_acc - a0) > 1000, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
